// File: rtl/packer_pkg.sv
// Shared types and default geometry for the narrow-to-wide word packer.
package packer_pkg;

    localparam int IN_BYTES_DEF  = 32;
    localparam int OUT_WORDS_DEF = 5;
    localparam int VBCW_DEF      = 8;
    localparam int BEAT_BYTES    = IN_BYTES_DEF * OUT_WORDS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        CONT  = 2'd2
    } state_e;

endpackage

// File: rtl/packer_out_stage.sv
// Output beat register: loads a finished beat and holds it until downstream takes it.
module packer_out_stage
    import packer_pkg::*;
#(
    parameter int VBCW = VBCW_DEF,
    parameter int DW   = BEAT_BYTES * 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            sop_i,
    input  logic            eop_i,
    input  logic            err_i,
    input  logic [VBCW-1:0] vbc_i,
    input  logic [DW-1:0]   data_i,
    input  logic            beat_ready_i,
    output logic            in_ready_o,
    output logic            val_o,
    output logic            sop_o,
    output logic            eop_o,
    output logic            err_o,
    output logic [VBCW-1:0] vbc_o,
    output logic [DW-1:0]   data_o
);

    logic            val_q, val_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;
    logic [VBCW-1:0] vbc_q, vbc_d;
    logic [DW-1:0]   data_q, data_d;

    always_comb begin
        val_d  = val_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        err_d  = err_q;
        vbc_d  = vbc_q;
        data_d = data_q;
        // A load can only happen while in_ready_o is high, so it never overwrites an untaken beat.
        if (load_i) begin
            val_d  = 1'b1;
            sop_d  = sop_i;
            eop_d  = eop_i;
            err_d  = err_i;
            vbc_d  = vbc_i;
            data_d = data_i;
        end else if (val_q && beat_ready_i) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q  <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            err_q  <= 1'b0;
            vbc_q  <= '0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
            err_q  <= err_d;
            vbc_q  <= vbc_d;
            data_q <= data_d;
        end
    end

    assign in_ready_o = !val_q || beat_ready_i;
    assign val_o      = val_q;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
    assign err_o      = err_q;
    assign vbc_o      = vbc_q;
    assign data_o     = data_q;

endmodule

// File: rtl/packer_fsm.sv
// Packs IN_BYTES-wide words into OUT_WORDS-word beats, splitting long packets across beats.
//   state | meaning
//   IDLE  | no packet open; only a legal sop word is taken, anything else is dropped
//   FIRST | packet open, its first beat not yet emitted (next beat carries sop)
//   CONT  | packet open, at least one beat already emitted
module packer_fsm
    import packer_pkg::*;
#(
    parameter int IN_BYTES  = IN_BYTES_DEF,
    parameter int OUT_WORDS = OUT_WORDS_DEF,
    parameter int VBCW      = VBCW_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            val,
    input  logic                            sop,
    input  logic                            eop,
    input  logic [VBCW-1:0]                 vbc,
    input  logic [IN_BYTES*8-1:0]           data,
    output logic                            ready,
    input  logic                            o_ready,
    output logic                            o_val,
    output logic                            o_sop,
    output logic                            o_eop,
    output logic                            o_err,
    output logic [VBCW-1:0]                 o_vbc,
    output logic [OUT_WORDS*IN_BYTES*8-1:0] o_data,
    output logic                            o_drop,
    output logic                            idle
);

    localparam int WW = IN_BYTES * 8;
    localparam int AW = OUT_WORDS * WW;
    localparam int CW = $clog2(OUT_WORDS + 1);
    localparam logic [CW-1:0]   LAST_CNT   = CW'(OUT_WORDS - 1);
    localparam logic [VBCW-1:0] IN_BYTES_V = VBCW'(IN_BYTES);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            drop_q, drop_d;

    logic            accept, legal, last_word;
    logic [AW-1:0]   acc_shift;
    logic [VBCW-1:0] count_bytes;
    logic            load;
    logic            b_sop, b_eop, b_err;
    logic [VBCW-1:0] b_vbc;
    logic [AW-1:0]   b_data;

    assign accept      = val && ready;
    assign legal       = (vbc != '0) && (vbc <= IN_BYTES_V) && (eop || (vbc == IN_BYTES_V));
    assign last_word   = eop || (count_q == LAST_CNT);
    assign acc_shift   = {acc_q[AW-WW-1:0], data};
    assign count_bytes = VBCW'(count_q) * IN_BYTES_V;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        drop_d  = 1'b0;
        load    = 1'b0;
        b_sop   = 1'b0;
        b_eop   = 1'b0;
        b_err   = 1'b0;
        b_vbc   = '0;
        b_data  = acc_shift;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sop && legal) begin
                        if (last_word) begin
                            load    = 1'b1;
                            b_sop   = 1'b1;
                            b_eop   = eop;
                            b_vbc   = vbc;
                            count_d = '0;
                            acc_d   = '0;
                            state_d = eop ? IDLE : CONT;
                        end else begin
                            count_d = CW'(1);
                            acc_d   = acc_shift;
                            state_d = FIRST;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                FIRST, CONT: begin
                    if (sop || !legal) begin
                        // Abort: flush whatever was collected, the offending word is not included.
                        load    = 1'b1;
                        b_sop   = (state_q == FIRST);
                        b_eop   = 1'b1;
                        b_err   = 1'b1;
                        b_vbc   = count_bytes;
                        b_data  = acc_q;
                        count_d = '0;
                        acc_d   = '0;
                        state_d = IDLE;
                    end else if (last_word) begin
                        load    = 1'b1;
                        b_sop   = (state_q == FIRST);
                        b_eop   = eop;
                        b_vbc   = count_bytes + vbc;
                        count_d = '0;
                        acc_d   = '0;
                        state_d = eop ? IDLE : CONT;
                    end else begin
                        count_d = count_q + CW'(1);
                        acc_d   = acc_shift;
                    end
                end
                default: begin
                    count_d = '0;
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

    packer_out_stage #(
        .VBCW (VBCW),
        .DW   (AW)
    ) u_out (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .sop_i        (b_sop),
        .eop_i        (b_eop),
        .err_i        (b_err),
        .vbc_i        (b_vbc),
        .data_i       (b_data),
        .beat_ready_i (o_ready),
        .in_ready_o   (ready),
        .val_o        (o_val),
        .sop_o        (o_sop),
        .eop_o        (o_eop),
        .err_o        (o_err),
        .vbc_o        (o_vbc),
        .data_o       (o_data)
    );

    assign o_drop = drop_q;
    assign idle   = (state_q == IDLE) && !o_val;

endmodule
